// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// The FSM state enum, requester ids and counter widths.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } arb_state_e;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_LD    = 1'b1;

   localparam int unsigned LAT_CNT_W    = 2;
   localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational winner selection between fetch and loader.
// Fetch wins unless the loader has waited LOADER_MAX_WAIT fetch grants.
module imem_arb_pick
   import imem_arb_pkg::*;
#(
   parameter int unsigned LOADER_MAX_WAIT = 4
) (
   input  logic                    fetch_req,
   input  logic                    ld_req,
   input  logic [STARVE_CNT_W-1:0] starve_cnt,
   input  logic                    arb_en,
   output logic                    fetch_gnt,
   output logic                    ld_gnt,
   output logic                    win_id
);

   logic ld_due;

   always_comb begin
      ld_due    = (starve_cnt == STARVE_CNT_W'(LOADER_MAX_WAIT));
      ld_gnt    = arb_en & ld_req & (ld_due | ~fetch_req);
      fetch_gnt = arb_en & fetch_req & ~ld_gnt;
      win_id    = ld_gnt ? REQ_LD : REQ_FETCH;
   end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction SRAM arbiter: fetch (read) and loader (read/write).
// One access in flight at a time; grants are possible in IDLE and DONE.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 20,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MEM_LATENCY     = 1,
   parameter int unsigned LOADER_MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_req_in,
   input  logic [ADDR_WIDTH-1:0] fetch_addr_in,
   output logic                  fetch_gnt_out,
   output logic [DATA_WIDTH-1:0] fetch_data_out,
   output logic                  fetch_valid_out,
   input  logic                  ld_req_in,
   input  logic                  ld_we_in,
   input  logic [ADDR_WIDTH-1:0] ld_addr_in,
   input  logic [DATA_WIDTH-1:0] ld_wdata_in,
   output logic                  ld_gnt_out,
   output logic [DATA_WIDTH-1:0] ld_rdata_out,
   output logic                  ld_valid_out,
   output logic                  mem_en_out,
   output logic                  mem_we_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   output logic [DATA_WIDTH-1:0] mem_wdata_out,
   input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

   arb_state_e              state_q, state_d;
   logic                    owner_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [LAT_CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [DATA_WIDTH-1:0]   fetch_data_q;
   logic [DATA_WIDTH-1:0]   ld_data_q;
   logic                    arb_en;
   logic                    win_id;
   logic                    any_gnt;
   logic                    capture;

   // Grants are suppressed while reset is held so every output reads 0.
   assign arb_en  = rst_n & ((state_q == StIdle) | (state_q == StDone));
   assign any_gnt = fetch_gnt_out | ld_gnt_out;

   imem_arb_pick #(
      .LOADER_MAX_WAIT(LOADER_MAX_WAIT)
   ) u_pick (
      .fetch_req (fetch_req_in),
      .ld_req    (ld_req_in),
      .starve_cnt(starve_cnt_q),
      .arb_en    (arb_en),
      .fetch_gnt (fetch_gnt_out),
      .ld_gnt    (ld_gnt_out),
      .win_id    (win_id)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= REQ_FETCH;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         fetch_data_q <= '0;
         ld_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         if (any_gnt) begin
            owner_q <= win_id;
            we_q    <= (win_id == REQ_LD) & ld_we_in;
            addr_q  <= (win_id == REQ_LD) ? ld_addr_in : fetch_addr_in;
            wdata_q <= ld_wdata_in;
         end
         if (capture && owner_q == REQ_FETCH) fetch_data_q <= mem_rdata_in;
         if (capture && owner_q == REQ_LD && !we_q) ld_data_q <= mem_rdata_in;
      end
   end

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      capture   = 1'b0;
      unique case (state_q)
         StIdle: if (any_gnt) state_d = StIssue;
         StIssue: begin
            lat_cnt_d = LAT_CNT_W'(MEM_LATENCY - 1);
            state_d   = StWait;
         end
         StWait: begin
            if (lat_cnt_q == '0) begin
               capture = 1'b1;
               state_d = StDone;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         StDone: state_d = any_gnt ? StIssue : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Saturates at LOADER_MAX_WAIT; at that value the loader wins anyway.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!ld_req_in || ld_gnt_out) begin
         starve_cnt_d = '0;
      end else if (fetch_gnt_out && starve_cnt_q != STARVE_CNT_W'(LOADER_MAX_WAIT)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      mem_en_out      = (state_q == StIssue);
      mem_we_out      = mem_en_out & we_q;
      mem_addr_out    = mem_en_out ? addr_q : '0;
      mem_wdata_out   = mem_we_out ? wdata_q : '0;
      fetch_valid_out = (state_q == StDone) & (owner_q == REQ_FETCH);
      ld_valid_out    = (state_q == StDone) & (owner_q == REQ_LD);
      fetch_data_out  = fetch_data_q;
      ld_rdata_out    = ld_data_q;
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: cycle-level reference model feeding a scoreboard,
// directed scenarios plus randomized fetch/loader traffic.
`timescale 1ns/1ps
module tb_imem_arbiter;

   localparam int unsigned AW   = 20;
   localparam int unsigned DW   = 32;
   localparam int unsigned LAT  = 1;
   localparam int unsigned MAXW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_req_in, ld_req_in, ld_we_in;
   logic [AW-1:0] fetch_addr_in, ld_addr_in;
   logic [DW-1:0] ld_wdata_in;
   logic          fetch_gnt_out, fetch_valid_out, ld_gnt_out, ld_valid_out;
   logic [DW-1:0] fetch_data_out, ld_rdata_out;
   logic          mem_en_out, mem_we_out;
   logic [AW-1:0] mem_addr_out;
   logic [DW-1:0] mem_wdata_out, mem_rdata_in;

   // Second instance at MEM_LATENCY=4, fetch side only.
   logic          f4_req;
   logic [AW-1:0] f4_addr;
   logic          f4_gnt, f4_valid, l4_gnt, l4_valid, m4_en, m4_we;
   logic [DW-1:0] f4_data, l4_rdata, m4_wdata, m4_rdata;
   logic [AW-1:0] m4_addr;

   always #5 clk = ~clk;

   imem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .LOADER_MAX_WAIT(MAXW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req_in(fetch_req_in), .fetch_addr_in(fetch_addr_in),
      .fetch_gnt_out(fetch_gnt_out), .fetch_data_out(fetch_data_out),
      .fetch_valid_out(fetch_valid_out),
      .ld_req_in(ld_req_in), .ld_we_in(ld_we_in), .ld_addr_in(ld_addr_in),
      .ld_wdata_in(ld_wdata_in), .ld_gnt_out(ld_gnt_out), .ld_rdata_out(ld_rdata_out),
      .ld_valid_out(ld_valid_out),
      .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
      .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
   );

   imem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(4), .LOADER_MAX_WAIT(4)
   ) dut4 (
      .clk(clk), .rst_n(rst_n),
      .fetch_req_in(f4_req), .fetch_addr_in(f4_addr),
      .fetch_gnt_out(f4_gnt), .fetch_data_out(f4_data), .fetch_valid_out(f4_valid),
      .ld_req_in(1'b0), .ld_we_in(1'b0), .ld_addr_in('0), .ld_wdata_in('0),
      .ld_gnt_out(l4_gnt), .ld_rdata_out(l4_rdata), .ld_valid_out(l4_valid),
      .mem_en_out(m4_en), .mem_we_out(m4_we), .mem_addr_out(m4_addr),
      .mem_wdata_out(m4_wdata), .mem_rdata_in(m4_rdata)
   );

   // SRAM models
   logic          img_load;
   logic [DW-1:0] refmem [64];
   logic [DW-1:0] sram [64];
   logic [DW-1:0] rd_pipe [LAT];
   logic [DW-1:0] p4 [4];

   always @(posedge clk) begin
      if (img_load) begin
         for (int i = 0; i < 64; i++) sram[i] <= refmem[i];
      end else if (mem_en_out && mem_we_out) begin
         sram[mem_addr_out[5:0]] <= mem_wdata_out;
      end
      rd_pipe[0] <= (mem_en_out && !mem_we_out) ? sram[mem_addr_out[5:0]] : $urandom;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      p4[0] <= m4_en ? (32'hA5A5_0000 ^ {12'h0, m4_addr}) : 32'h0;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   assign mem_rdata_in = rd_pipe[LAT-1];
   assign m4_rdata     = p4[3];

   // Scoreboard state
   typedef struct {
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;
   typedef struct {
      int            cyc;
      logic          id;
      logic [DW-1:0] data;
   } rsp_t;

   acc_t          acc_q[$];
   rsp_t          rsp_q[$];
   int            dut_order[$];
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            free_cyc = 0;
   int            starve = 0;
   logic [DW-1:0] ld_last = '0;
   logic          g_f = 1'b0, g_l = 1'b0;
   logic          hold = 1'b0;
   logic          rst_prev_low = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one access at a time, next grant at grant+2+LAT.
   task automatic model_eval();
      logic          ef, el, arb, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] d;
      acc_t          a;
      rsp_t          r;
      if (!rst_n) begin
         check("gnt_in_reset", {fetch_gnt_out, ld_gnt_out}, 2'b00);
         if (rst_prev_low)
            check("outputs_in_reset", |{fetch_gnt_out, fetch_data_out, fetch_valid_out,
                  ld_gnt_out, ld_rdata_out, ld_valid_out, mem_en_out, mem_we_out,
                  mem_addr_out, mem_wdata_out}, 0);
         acc_q.delete();
         rsp_q.delete();
         free_cyc = 0;
         starve = 0;
         ld_last = '0;
         g_f = 1'b0;
         g_l = 1'b0;
         rst_prev_low = 1'b1;
         return;
      end
      rst_prev_low = 1'b0;
      arb = (cyc >= free_cyc);
      el  = arb && ld_req_in && (!fetch_req_in || starve == int'(MAXW));
      ef  = arb && fetch_req_in && !el;
      check("grant", {fetch_gnt_out, ld_gnt_out}, {ef, el});
      if (fetch_gnt_out) dut_order.push_back(0);
      if (ld_gnt_out) dut_order.push_back(1);
      if (!ld_req_in || el) starve = 0;
      else if (ef && starve < int'(MAXW)) starve++;
      if (ef || el) begin
         free_cyc = cyc + 2 + int'(LAT);
         addr = el ? ld_addr_in : fetch_addr_in;
         we   = el && ld_we_in;
         a.cyc = cyc + 1; a.we = we; a.addr = addr; a.wdata = ld_wdata_in;
         acc_q.push_back(a);
         if (we) refmem[addr[5:0]] = ld_wdata_in;
         d = we ? ld_last : refmem[addr[5:0]];
         if (el && !we) ld_last = d;
         r.cyc = cyc + 2 + int'(LAT); r.id = el; r.data = d;
         rsp_q.push_back(r);
      end
      g_f = ef;
      g_l = el;
   endtask

   // Monitor: pops the scoreboard whenever an access or response is due.
   logic          m_en, v_exp;
   logic [1:0]    v_vec;
   acc_t          m_a;
   rsp_t          m_r;
   always @(negedge clk) begin
      if (rst_n) begin
         m_en = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
         check("mem_en", mem_en_out, m_en);
         if (m_en) begin
            m_a = acc_q.pop_front();
            check("mem_we", mem_we_out, m_a.we);
            check("mem_addr", mem_addr_out, m_a.addr);
            if (m_a.we) check("mem_wdata", mem_wdata_out, m_a.wdata);
         end
         v_exp = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
         v_vec = v_exp ? (rsp_q[0].id ? 2'b01 : 2'b10) : 2'b00;
         check("valid", {fetch_valid_out, ld_valid_out}, v_vec);
         if (v_exp) begin
            m_r = rsp_q.pop_front();
            if (m_r.id) check("ld_rdata", ld_rdata_out, m_r.data);
            else check("fetch_data", fetch_data_out, m_r.data);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      model_eval();
      @(posedge clk);
      #1;
      if (!hold) begin
         if (g_f) fetch_req_in = 1'b0;
         if (g_l) ld_req_in = 1'b0;
      end
   endtask

   task automatic settle();
      int n = 0;
      while ((fetch_req_in || ld_req_in || rsp_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      check("settle_in_time", n < 100, 1);
   endtask

   task automatic l4_test();
      int            t_g[$];
      int            t_v[$];
      logic [DW-1:0] dv[$];
      f4_addr = 20'h00123;
      f4_req  = 1'b1;
      for (int n = 0; n < 40 && t_v.size() < 2; n++) begin
         @(negedge clk);
         if (f4_gnt) t_g.push_back(cyc);
         if (f4_valid) begin
            t_v.push_back(cyc);
            dv.push_back(f4_data);
         end
         @(posedge clk);
         #1;
         if (t_g.size() >= 2) f4_req = 1'b0;
      end
      f4_req = 1'b0;
      check("l4_events_seen", (t_g.size() >= 2) && (t_v.size() >= 2), 1);
      if (t_g.size() >= 2 && t_v.size() >= 2) begin
         check("l4_valid_latency", t_v[0] - t_g[0], 6);
         check("l4_second_grant", t_g[1] - t_g[0], 6);
         check("l4_second_valid", t_v[1] - t_g[1], 6);
         check("l4_data", dv[0], 32'hA5A5_0000 ^ 32'h0000_0123);
      end
   endtask

   int exp_order[6] = '{0, 0, 1, 0, 0, 1};

   initial begin
      rst_n = 1'b0;
      fetch_req_in = 1'b0; fetch_addr_in = '0;
      ld_req_in = 1'b0; ld_we_in = 1'b0; ld_addr_in = '0; ld_wdata_in = '0;
      f4_req = 1'b0; f4_addr = '0;
      for (int i = 0; i < 64; i++) refmem[i] = $urandom;
      refmem[4] = 32'hDEAD_BEEF;
      img_load = 1'b1;
      @(posedge clk);
      #1;
      img_load = 1'b0;

      // Both requesters pending across reset exit: fetch first, loader in its DONE.
      fetch_addr_in = 20'h00004; fetch_req_in = 1'b1;
      ld_addr_in = 20'h00008; ld_we_in = 1'b0; ld_req_in = 1'b1;
      tick(); tick(); tick();
      rst_n = 1'b1;
      settle();
      check("sim_fetch_data", fetch_data_out, 32'hDEAD_BEEF);

      // Fetch alone
      fetch_addr_in = 20'h00004; fetch_req_in = 1'b1;
      settle();
      check("fetch_alone_data", fetch_data_out, 32'hDEAD_BEEF);

      // Loader write then fetch readback
      ld_addr_in = 20'h00010; ld_we_in = 1'b1; ld_wdata_in = 32'h1234_5678; ld_req_in = 1'b1;
      settle();
      fetch_addr_in = 20'h00010; fetch_req_in = 1'b1;
      settle();
      check("readback_data", fetch_data_out, 32'h1234_5678);

      // Both requests held high continuously
      hold = 1'b1;
      dut_order.delete();
      fetch_addr_in = 20'h00004; fetch_req_in = 1'b1;
      ld_addr_in = 20'h00008; ld_we_in = 1'b0; ld_req_in = 1'b1;
      for (int n = 0; n < 60 && dut_order.size() < 6; n++) tick();
      hold = 1'b0;
      fetch_req_in = 1'b0;
      ld_req_in = 1'b0;
      check("order_count", dut_order.size() >= 6, 1);
      for (int i = 0; i < 6 && i < dut_order.size(); i++) check("grant_order", dut_order[i], exp_order[i]);
      settle();

      // Reset while the fetch is in WAIT
      fetch_addr_in = 20'h00004; fetch_req_in = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      fetch_addr_in = 20'h00008; fetch_req_in = 1'b1;
      settle();

      l4_test();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!fetch_req_in) begin
            if ($urandom_range(2) == 0) begin
               fetch_addr_in = AW'($urandom_range(63));
               fetch_req_in  = 1'b1;
            end
         end else if ($urandom_range(15) == 0) begin
            fetch_req_in = 1'b0;
         end
         if (!ld_req_in) begin
            if ($urandom_range(3) == 0) begin
               ld_addr_in  = AW'($urandom_range(63));
               ld_we_in    = 1'($urandom_range(1));
               ld_wdata_in = $urandom;
               ld_req_in   = 1'b1;
            end
         end else if ($urandom_range(15) == 0) begin
            ld_req_in = 1'b0;
         end
      end
      settle();
      check("scoreboard_drained", acc_q.size() + rsp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port instruction SRAM arbiter for the uDLX core. Shares one instruction memory between two requesters: the fetch stage (read-only) and a program loader/debug port (read/write). Runs one access at a time. Fetch has priority, and a counter guarantees the loader a slot. It sits between the fetch stage's `inst_mem_addr_out`/`inst_mem_data_in` path and the physical SRAM.

## Interface
- `ADDR_WIDTH`, 20, SRAM address width (matches PC width)
- `DATA_WIDTH`, 32, SRAM data width (instruction width)
- `MEM_LATENCY`, 1, cycles from enable cycle to read data on `mem_rdata_in`; legal 1..4
- `LOADER_MAX_WAIT`, 4, max consecutive fetch grants while loader is pending; legal 1..15

Ports:
- `clk` in 1: core clock; single clock domain
- `rst_n` in 1: reset, **synchronous, active-low**
- `fetch_req_in` in 1: fetch read request
- `fetch_addr_in` in ADDR_WIDTH: fetch address
- `fetch_gnt_out` out 1: fetch request accepted this cycle
- `fetch_data_out` out DATA_WIDTH: fetched instruction
- `fetch_valid_out` out 1: `fetch_data_out` valid (1-cycle pulse)
- `ld_req_in` in 1: loader request
- `ld_we_in` in 1: 1 = write, 0 = read
- `ld_addr_in` in ADDR_WIDTH: loader address
- `ld_wdata_in` in DATA_WIDTH: loader write data
- `ld_gnt_out` out 1: loader request accepted this cycle
- `ld_rdata_out` out DATA_WIDTH: loader read data
- `ld_valid_out` out 1: loader read data valid, or write done (1-cycle pulse)
- `mem_en_out` out 1: SRAM enable
- `mem_we_out` out 1: SRAM write enable
- `mem_addr_out` out ADDR_WIDTH: SRAM address
- `mem_wdata_out` out DATA_WIDTH: SRAM write data
- `mem_rdata_in` in DATA_WIDTH: SRAM read data

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - Arbitrate combinationally.
  - If any request is present, assert exactly one `*_gnt_out` and go to ISSUE.
  - Latch the winner's id, address, write data and we in the grant cycle.
- **ISSUE:**
  - `mem_en_out`=1; `mem_we_out`/`mem_addr_out`/`mem_wdata_out` come from the latched values.
  - Load the latency counter with MEM_LATENCY-1, then go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_rdata_in` into the owner's data register and go to DONE.
- **DONE:**
  - Pulse the owner's `*_valid_out`. Data registers hold their value until the next capture.
  - Arbitration is also active in DONE, so a new grant can occur here and the next state is ISSUE; otherwise the next state is IDLE.
- **Arbitration:**
  - Fetch wins by default.
  - `starve_cnt` counts fetch grants issued while `ld_req_in`=1.
  - When `starve_cnt`==LOADER_MAX_WAIT and `ld_req_in`=1, the loader wins.
  - `starve_cnt` clears on a loader grant or whenever `ld_req_in`=0.
  - The counter saturates and never wraps.
- **Requests:**
  - A requester holds req/addr/data stable until its grant.
  - Dropping req before grant is legal; no access results.
  - Inputs are ignored after grant.
- **Writes:** no data capture; `ld_valid_out` pulses as a write acknowledge with the same timing as a read.
- **Reset:**
  - All outputs 0, state IDLE, `starve_cnt` 0, data registers 0.
  - Reset asserted mid-access aborts the access: no valid pulse, and `mem_en_out`=0 from the next cycle.

## Timing
- Grant in cycle T.
- `mem_en_out` high in T+1 only.
- `mem_rdata_in` is sampled in T+1+MEM_LATENCY.
- `*_valid_out` high in T+2+MEM_LATENCY.
- Next grant is possible at earliest in T+2+MEM_LATENCY (the DONE cycle).
- Peak throughput: one access per MEM_LATENCY+2 cycles.
- `*_gnt_out` is combinational from req and state. No other output is combinational from inputs.
- Simultaneous req from both with `starve_cnt`<LOADER_MAX_WAIT: the fetch is granted and the loader waits.

## Structure
- **Package `imem_arb_pkg`:** state enum (IDLE/ISSUE/WAIT/DONE); requester-id constants (REQ_FETCH=0, REQ_LD=1); latency counter width (2 bits); starve counter width (4 bits).
- **Sub-module `imem_arb_pick`:** purely combinational winner selection. Inputs: both reqs, `starve_cnt`, arbitration-enable. Outputs: both grants and the winner id.
- The top holds the FSM, latches, counters and output registers.

## Test plan
- **Fetch alone** (MEM_LATENCY=1, SRAM model returns 0xDEADBEEF at 0x00004): `fetch_req_in`=1, addr 0x00004 in T → `fetch_gnt_out` T, `mem_en_out`=1/`mem_addr_out`=0x00004 in T+1, `fetch_valid_out`=1 and `fetch_data_out`=0xDEADBEEF in T+3.
- **Loader write then fetch readback:** `ld_we_in`=1, addr 0x00010, wdata 0x12345678 → `mem_we_out`=1 in T+1, `ld_valid_out` in T+3; then a fetch of 0x00010 returns 0x12345678.
- **Starvation bound** (LOADER_MAX_WAIT=2): both reqs held high continuously → grant order fetch, fetch, loader, fetch, fetch, loader.
- **Simultaneous requests at reset exit:** fetch granted first. The loader is granted in the fetch's DONE cycle, so its `mem_en_out` occurs exactly MEM_LATENCY+2 cycles after the fetch's `mem_en_out`.
- **Reset mid-access:** `rst_n`=0 in WAIT → no `fetch_valid_out`, all outputs 0 the next cycle. After release, a new fetch completes with nominal timing.
- **MEM_LATENCY=4:** a single fetch yields `fetch_valid_out` at T+6. A second fetch held high is granted at T+6.
